tanh_grad: RTL and testbench
============================

Name: tanh_grad

Overview:
- Backward-direction counterpart of the tanh activation unit, used by the neuron's training path.
- Takes the stored forward activation y = tanh(a) and an upstream gradient g, both fixed-point Q8.24.
- Produces the local gradient d = g * (1 - y^2) through a 3-stage pipeline with valid tracking, flush and a result counter.
- Sits between the neuron's activation buffer and the weight-update logic.

Parameters:
- WIDTH, 32: data word width in bits, two's complement.
- FL, 24: number of fractional bits (Q8.24 at defaults).
- CNT_W, 16: width of the result counter.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-low reset (0 = reset asserted).
- en  in  1  Pipeline advance. When 0, all stages, valids and the counter hold.
- flush  in  1  Synchronous clear of all valid bits; data registers keep their contents.
- in_valid  in  1  y and g are valid this cycle.
- y  in  WIDTH  Forward activation, Q8.24 signed.
- g  in  WIDTH  Upstream gradient, Q8.24 signed.
- d  out  WIDTH  Local gradient, Q8.24 signed, registered.
- out_valid  out  1  d is valid.
- res_cnt  out  CNT_W  Number of results emitted since reset, saturating.

Behaviour:
- Reset (rst=0, asynchronous) clears every pipeline register: d=0, out_valid=0, res_cnt=0, all internal valids=0.
- Input clamp (combinational, before stage 1): yc = y limited to [-1.0, +1.0], i.e. [0xFF000000, 0x01000000] at the defaults. Compare as signed.
- Stage 1 (en=1): register ysq = (yc*yc)[FL+WIDTH-1:FL] from a full 2*WIDTH signed product. Also register g and v1=in_valid.
  - Fractional bits are truncated (arithmetic floor); there is no rounding.
  - ysq lies in [0, 1.0].
- Stage 2: register om = ONE - ysq, which lies in [0, 1.0]. Carry g forward and set v2=v1.
- Stage 3:
  - p = g*om as a full 2*WIDTH signed product.
  - Take slice p[FL+WIDTH-1:FL], truncated.
  - Saturate to [0x80000000, 0x7FFFFFFF]. This never triggers for in-range inputs; it is kept defensively and checked by assertion.
  - Register the result to d and set out_valid=v2.
- Latency: 3 enabled clock edges from the in_valid sample to out_valid=1.
  - Throughput is one result per enabled cycle.
  - There is no backpressure beyond en.
- en=0: data, valids and res_cnt all frozen; inputs presented that cycle are ignored. While frozen, out_valid keeps its previous value and d holds.
- flush=1 on an edge:
  - v1, v2 and out_valid are cleared regardless of en.
  - A simultaneous in_valid is dropped; flush wins.
  - Data registers may update or hold; their contents are don't-care once invalid.
- res_cnt increments on each edge where en=1, flush=0 and v2=1, i.e. when a new result is loaded into d. It saturates at all-ones with no wrap.
- Reset asserted mid-operation drops all in-flight results with no partial output.
- Data registers load regardless of the valid bit (no gating on in_valid). Bubbles therefore carry garbage data with valid=0, which is acceptable.

Decomposition:
- Shared package:
  - WIDTH and FL defaults.
  - ONE_Q = 1<<FL.
  - NEG_ONE_Q = -(1<<FL).
  - Saturation limits MAX_Q / MIN_Q.
  - These are shared with the tanh forward unit.
- The existing enable/reset pipeline register module is reused for every stage register.
- New sub-module fx_mul_q:
  - Signed WIDTH×WIDTH multiply, shift right by FL (slice), saturate to WIDTH.
  - Purely combinational.
  - Instantiated twice: once for y^2 and once for g*om.

Test Plan:
- y=0x00000000, g=0x01000000, en=1, in_valid pulse -> after 3 edges out_valid=1, d=0x01000000, res_cnt=1.
- y=0x00800000 (0.5), g=0x01000000 -> d=0x00C00000 (0.75). Same y with g=0xFE000000 (-2.0) -> d=0xFE800000 (-1.5).
- Clamp: y=0x01800000 (1.5), g=0x02000000 -> d=0x00000000. y=0xFF000000 (-1.0), g=0x7FFFFFFF -> d=0.
- Back-to-back inputs y = 0, 0.5, -0.5 over 3 cycles with g=1.0, then en held low for 2 cycles mid-stream -> outputs 1.0, 0.75, 0.75 in order. out_valid and d hold during the stall; res_cnt=3 at the end.
- flush asserted while 2 results are in flight, together with a new in_valid -> no out_valid for any of the 3 inputs, res_cnt unchanged.
- rst driven low asynchronously between clock edges with out_valid=1 -> d=0, out_valid=0 and res_cnt=0 immediately. After rst is released, a fresh input yields correct results at 3-edge latency.

Source files
------------

// File: rtl/tanh_grad_pkg.sv
// Fixed-point constants shared by the tanh forward and backward units.
// Q8.24 by default: 1.0 is 0x01000000.
package tanh_grad_pkg;

  localparam int Q_WIDTH = 32;
  localparam int Q_FL    = 24;

  localparam logic [Q_WIDTH-1:0] ONE_Q     = Q_WIDTH'(1) << Q_FL;
  localparam logic [Q_WIDTH-1:0] NEG_ONE_Q = -ONE_Q;
  localparam logic [Q_WIDTH-1:0] MAX_Q     = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] MIN_Q     = {1'b1, {(Q_WIDTH-1){1'b0}}};

endpackage

// File: rtl/tanh_grad_fx_mul_q.sv
// Combinational signed fixed-point multiply: full product, floor-shift by FL,
// then saturate to WIDTH. sat flags that the result had to be clipped.
module fx_mul_q
  import tanh_grad_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FL    = Q_FL
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             sat
);

  logic signed [2*WIDTH-1:0] full;
  logic        [WIDTH-FL:0]  hi;

  assign full = $signed(a) * $signed(b);
  // Everything above the kept slice, plus its sign bit, must be a sign extension.
  assign hi   = full[2*WIDTH-1:FL+WIDTH-1];

  always_comb begin
    sat = 1'b0;
    p   = full[FL+WIDTH-1:FL];
    if (!((hi == '0) || (hi == '1))) begin
      sat = 1'b1;
      p   = full[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/tanh_grad_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear,
// load on enable. The clear takes effect whether or not en is high.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else if (en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/tanh_grad.sv
// Backward tanh: d = g * (1 - y^2), 3-stage pipeline with valid tracking,
// flush and a saturating result counter.
module tanh_grad
  import tanh_grad_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FL    = Q_FL,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [CNT_W-1:0] res_cnt
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FL;
  localparam logic [WIDTH-1:0] NEG_ONE = -ONE;

  logic [WIDTH-1:0] yc, ysq_next, ysq1, g1, om_next, om2, g2, d_next;
  logic             sat1, sat3;
  logic [3:0]       v;

  always_comb begin
    yc = y;
    if ($signed(y) > $signed(ONE)) begin
      yc = ONE;
    end else if ($signed(y) < $signed(NEG_ONE)) begin
      yc = NEG_ONE;
    end
  end

  fx_mul_q #(.WIDTH(WIDTH), .FL(FL)) u_sq (.a(yc), .b(yc), .p(ysq_next), .sat(sat1));

  pipe_reg #(.W(WIDTH)) u_ysq1 (.clk(clk), .rst(rst), .en(en), .clr(1'b0), .din(ysq_next), .dout(ysq1));
  pipe_reg #(.W(WIDTH)) u_g1   (.clk(clk), .rst(rst), .en(en), .clr(1'b0), .din(g),        .dout(g1));

  assign om_next = ONE - ysq1;

  pipe_reg #(.W(WIDTH)) u_om2  (.clk(clk), .rst(rst), .en(en), .clr(1'b0), .din(om_next),  .dout(om2));
  pipe_reg #(.W(WIDTH)) u_g2   (.clk(clk), .rst(rst), .en(en), .clr(1'b0), .din(g1),       .dout(g2));

  fx_mul_q #(.WIDTH(WIDTH), .FL(FL)) u_gom (.a(g2), .b(om2), .p(d_next), .sat(sat3));

  pipe_reg #(.W(WIDTH)) u_d    (.clk(clk), .rst(rst), .en(en), .clr(1'b0), .din(d_next),   .dout(d));

  // Valid chain: v[0] is the input strobe, v[3] drives out_valid.
  assign v[0] = in_valid;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_valid
      pipe_reg #(.W(1)) u_v (
        .clk(clk), .rst(rst), .en(en), .clr(flush), .din(v[gi]), .dout(v[gi+1])
      );
    end
  endgenerate

  assign out_valid = v[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_cnt <= '0;
    end else if (en && !flush && v[2] && (res_cnt != '1)) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

  // Clamped inputs keep both products inside range; clipping would mean a datapath bug.
  a_no_sat_sq : assert property (@(posedge clk) disable iff (!rst) !(en && v[0] && sat1));
  a_no_sat_gm : assert property (@(posedge clk) disable iff (!rst) !(en && v[2] && sat3));

endmodule

// File: tb/tb_tanh_grad.sv
// Directed bench for tanh_grad with hand-computed Q8.24 expectations.
module tb_tanh_grad;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] y = '0;
  logic [31:0] g = '0;
  logic [31:0] d;
  logic        out_valid;
  logic [15:0] res_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  tanh_grad dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .y(y), .g(g), .d(d), .out_valid(out_valid), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One isolated transaction: check it is not early, then check the 3-edge result.
  task automatic single(input string tag, input logic [31:0] yv, input logic [31:0] gv,
                        input logic [31:0] dexp);
    y = yv; g = gv; in_valid = 1'b1;
    step();
    in_valid = 1'b0; y = 32'hDEAD_BEEF; g = 32'h1234_5678;
    step();
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    exp_cnt++;
    chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_d"}, d, dexp);
    chk({tag, "_cnt"}, {16'd0, res_cnt}, 32'(exp_cnt));
    $display("txn %s y=%h g=%h d=%h cnt=%0d", tag, yv, gv, d, res_cnt);
    step();
  endtask

  initial begin
    step();
    chk("rst_d", d, 32'd0);
    chk("rst_v", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", {16'd0, res_cnt}, 32'd0);
    rst = 1'b1; en = 1'b1;
    step();

    single("y0",      32'h0000_0000, 32'h0100_0000, 32'h0100_0000);
    single("yhalf",   32'h0080_0000, 32'h0100_0000, 32'h00C0_0000);
    single("yhalf_n", 32'h0080_0000, 32'hFE00_0000, 32'hFE80_0000);
    single("clamp_p", 32'h0180_0000, 32'h0200_0000, 32'h0000_0000);
    single("clamp_n", 32'hFF00_0000, 32'h7FFF_FFFF, 32'h0000_0000);

    // Back-to-back stream with a 2-cycle stall after the first result.
    g = 32'h0100_0000; in_valid = 1'b1;
    y = 32'h0000_0000; step();
    y = 32'h0080_0000; step();
    y = 32'hFF80_0000; step();
    exp_cnt++;
    chk("bb0_v", {31'd0, out_valid}, 32'd1);
    chk("bb0_d", d, 32'h0100_0000);
    $display("txn bb0 d=%h cnt=%0d", d, res_cnt);
    en = 1'b0; y = 32'h0180_0000; g = 32'h0300_0000;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_v", {31'd0, out_valid}, 32'd1);
      chk("stall_d", d, 32'h0100_0000);
      chk("stall_cnt", {16'd0, res_cnt}, 32'(exp_cnt));
    end
    en = 1'b1; in_valid = 1'b0;
    step();
    exp_cnt++;
    chk("bb1_v", {31'd0, out_valid}, 32'd1);
    chk("bb1_d", d, 32'h00C0_0000);
    $display("txn bb1 d=%h cnt=%0d", d, res_cnt);
    step();
    exp_cnt++;
    chk("bb2_v", {31'd0, out_valid}, 32'd1);
    chk("bb2_d", d, 32'h00C0_0000);
    $display("txn bb2 d=%h cnt=%0d", d, res_cnt);
    step();
    chk("bb_end_v", {31'd0, out_valid}, 32'd0);
    chk("bb_end_cnt", {16'd0, res_cnt}, 32'(exp_cnt));

    // Flush with two results in flight and a third arriving on the same edge.
    g = 32'h0100_0000; in_valid = 1'b1;
    y = 32'h0000_0000; step();
    y = 32'h0080_0000; step();
    y = 32'h0040_0000; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_v0", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_v", {31'd0, out_valid}, 32'd0);
    end
    chk("flush_cnt", {16'd0, res_cnt}, 32'(exp_cnt));
    $display("txn flush cnt=%0d", res_cnt);

    // Asynchronous reset between edges while a result is being shown.
    y = 32'h0000_0000; g = 32'h0200_0000; in_valid = 1'b1; step();
    in_valid = 1'b0; step(); step();
    exp_cnt++;
    chk("pre_rst_v", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_d", d, 32'h0200_0000);
    #2 rst = 1'b0;
    #1;
    chk("arst_d", d, 32'd0);
    chk("arst_v", {31'd0, out_valid}, 32'd0);
    chk("arst_cnt", {16'd0, res_cnt}, 32'd0);
    $display("txn async_reset d=%h v=%0d cnt=%0d", d, out_valid, res_cnt);
    #2 rst = 1'b1;
    exp_cnt = 0;
    step();
    single("post_rst", 32'hFF80_0000, 32'hFC00_0000, 32'hFD00_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
